// File: rtl/seg_display_decoder.sv
// ----------------------------------------------------------------------------
// seg_display_decoder
//
// Watches a multiplexed 7-segment bus and turns it back into a binary number.
// Each digit strobe has to be stable for SETTLE cycles before its segment
// pattern is captured. Four captured slots make one frame. A frame's value is
// published only after MATCH_FRAMES consecutive identical error-free frames.
//
// Ports:
//   CLK           system clock, the only clock
//   RESET         synchronous, active-high reset
//   seg[7:0]      observed segments, active-low; [6:0]=g..a, [7]=dp
//   digit[3:0]    observed anodes, active-low one-hot; [0]=ones .. [3]=thousands
//   number        last published value (0..9999)
//   number_valid  one-cycle pulse when number is (re)published
//   locked        high while the published value is confirmed and the scan is alive
//   frame_err     one-cycle pulse when a completed frame held an undecodable digit
//   dp_mask[3:0]  decimal points of the last published frame (1 = lit)
// ----------------------------------------------------------------------------
module seg_display_decoder #(
  parameter int SETTLE       = 16,
  parameter int MATCH_FRAMES = 2,
  parameter int TIMEOUT      = 500000,
  parameter int NUM_W        = 14
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       seg,
  input  logic [3:0]       digit,
  output logic [NUM_W-1:0] number,
  output logic             number_valid,
  output logic             locked,
  output logic             frame_err,
  output logic [3:0]       dp_mask
);

  localparam int CNT_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam int MCH_W = $clog2(MATCH_FRAMES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  // The capture fires on the edge where the settle counter becomes SETTLE-1.
  localparam logic [CNT_W-1:0] SET_CAP   = CNT_W'(SETTLE - 2);
  localparam logic [CNT_W-1:0] SET_MAX   = CNT_W'(SETTLE - 1);
  localparam logic [MCH_W-1:0] MATCH_MAX = MCH_W'(MATCH_FRAMES);
  localparam logic [TO_W-1:0]  TO_HIT    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_CAPTURE = 2'd0,
    S_CONVERT = 2'd1,
    S_COMPARE = 2'd2
  } state_t;

  // {error, digit}; blank decodes as 0 without error.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'd0;
      7'b1111001: r = 5'd1;
      7'b0100100: r = 5'd2;
      7'b0110000: r = 5'd3;
      7'b0011001: r = 5'd4;
      7'b0010010: r = 5'd5;
      7'b0000010: r = 5'd6;
      7'b1111000: r = 5'd7;
      7'b0000000: r = 5'd8;
      7'b0010000: r = 5'd9;
      7'b1111111: r = 5'd0;
      default:    r = 5'b1_0000;
    endcase
    return r;
  endfunction

  state_t            r_state;
  state_t            w_state_next;

  logic [7:0]        r_seg_q;
  logic [3:0]        r_digit_q;
  logic [3:0]        r_digit_prev;
  logic [CNT_W-1:0]  r_settle_cnt;
  logic              r_captured;

  logic [3:0]        r_seen;
  logic              r_err;
  logic [3:0]        r_dig [4];
  logic [3:0]        r_dp;

  logic [3:0]        r_fdig [4];
  logic [3:0]        r_fdp;
  logic              r_ferr;
  logic [NUM_W-1:0]  r_value;

  logic [NUM_W-1:0]  r_ref_value;
  logic [3:0]        r_ref_dp;
  logic [MCH_W-1:0]  r_match;
  logic [TO_W-1:0]   r_to_cnt;

  logic [NUM_W-1:0]  r_number;
  logic              r_number_valid;
  logic              r_locked;
  logic              r_frame_err;
  logic [3:0]        r_dp_mask;

  logic              w_valid;
  logic [1:0]        w_slot;
  logic              w_stable;
  logic              w_cap;
  logic [4:0]        w_dec;
  logic [3:0]        w_cap_bit;
  logic [3:0]        w_seen_next;
  logic              w_err_next;
  logic [3:0]        w_dig_next [4];
  logic [3:0]        w_dp_next;
  logic              w_complete;
  logic              w_to_fire;
  logic [NUM_W-1:0]  w_value;
  logic              w_same;
  logic [MCH_W-1:0]  w_match_inc;
  logic [MCH_W-1:0]  w_match_new;
  logic              w_publish;

  // Only a single low anode selects a slot; blank and multi-low are ignored.
  always_comb begin
    w_valid = 1'b1;
    w_slot  = 2'd0;
    case (r_digit_q)
      4'b1110: w_slot = 2'd0;
      4'b1101: w_slot = 2'd1;
      4'b1011: w_slot = 2'd2;
      4'b0111: w_slot = 2'd3;
      default: w_valid = 1'b0;
    endcase
  end

  assign w_stable    = w_valid && (r_digit_q == r_digit_prev);
  assign w_cap       = w_stable && !r_captured && (r_settle_cnt == SET_CAP);
  assign w_dec       = decode(r_seg_q[6:0]);
  assign w_cap_bit   = w_cap ? (4'b0001 << w_slot) : 4'b0000;
  assign w_seen_next = r_seen | w_cap_bit;
  assign w_err_next  = r_err | (w_cap & w_dec[4]);

  // Completion looks at the post-capture mask so the final slot is included
  // in the snapshot taken on the same edge.
  assign w_complete  = (r_state == S_CAPTURE) && (w_seen_next == 4'b1111);
  assign w_to_fire   = (r_to_cnt == TO_HIT) && !w_complete;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign w_dig_next[gi] = w_cap_bit[gi] ? w_dec[3:0] : r_dig[gi];
    assign w_dp_next[gi]  = w_cap_bit[gi] ? ~r_seg_q[7] : r_dp[gi];
  end

  assign w_value = NUM_W'(r_fdig[3]) * NUM_W'(1000)
                 + NUM_W'(r_fdig[2]) * NUM_W'(100)
                 + NUM_W'(r_fdig[1]) * NUM_W'(10)
                 + NUM_W'(r_fdig[0]);

  assign w_same      = (r_value == r_ref_value) && (r_fdp == r_ref_dp);
  assign w_match_inc = (r_match == MATCH_MAX) ? r_match : r_match + MCH_W'(1);
  assign w_match_new = w_same ? w_match_inc : MCH_W'(1);
  // A differing frame that alone satisfies MATCH_FRAMES (=1) also publishes.
  assign w_publish   = (w_match_new == MATCH_MAX) && (!w_same || (r_match != MATCH_MAX));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CAPTURE: if (w_complete) w_state_next = S_CONVERT;
      S_CONVERT: w_state_next = S_COMPARE;
      S_COMPARE: w_state_next = S_CAPTURE;
      default:   w_state_next = S_CAPTURE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_CAPTURE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_seg_q        <= 8'hFF;
      r_digit_q      <= 4'hF;
      r_digit_prev   <= 4'hF;
      r_settle_cnt   <= '0;
      r_captured     <= 1'b0;
      r_seen         <= 4'b0000;
      r_err          <= 1'b0;
      r_dp           <= 4'b0000;
      r_fdp          <= 4'b0000;
      r_ferr         <= 1'b0;
      r_value        <= '0;
      r_ref_value    <= '0;
      r_ref_dp       <= 4'b0000;
      r_match        <= '0;
      r_to_cnt       <= '0;
      r_number       <= '0;
      r_number_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_frame_err    <= 1'b0;
      r_dp_mask      <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_dig[i]  <= 4'd0;
        r_fdig[i] <= 4'd0;
      end
    end else begin
      r_seg_q        <= seg;
      r_digit_q      <= digit;
      r_digit_prev   <= r_digit_q;
      r_number_valid <= 1'b0;
      r_frame_err    <= 1'b0;

      if (!w_stable) begin
        r_settle_cnt <= '0;
        r_captured   <= 1'b0;
      end else begin
        if (r_settle_cnt != SET_MAX) r_settle_cnt <= r_settle_cnt + CNT_W'(1);
        if (w_cap) r_captured <= 1'b1;
      end

      r_dig <= w_dig_next;
      r_dp  <= w_dp_next;

      // The slot mask and error flag restart on completion so the next frame
      // accumulates while this one is converted and compared.
      if (w_complete || w_to_fire) begin
        r_seen <= 4'b0000;
        r_err  <= 1'b0;
      end else begin
        r_seen <= w_seen_next;
        r_err  <= w_err_next;
      end

      if (w_complete) begin
        r_fdig <= w_dig_next;
        r_fdp  <= w_dp_next;
        r_ferr <= w_err_next;
      end

      if (r_state == S_CONVERT) r_value <= w_value;

      if (r_state == S_COMPARE) begin
        if (r_ferr) begin
          r_frame_err <= 1'b1;
          r_match     <= '0;
          r_locked    <= 1'b0;
        end else begin
          r_match  <= w_match_new;
          r_locked <= (w_match_new == MATCH_MAX);
          if (!w_same) begin
            r_ref_value <= r_value;
            r_ref_dp    <= r_fdp;
          end
          if (w_publish) begin
            r_number       <= r_value;
            r_dp_mask      <= r_fdp;
            r_number_valid <= 1'b1;
          end
        end
      end

      if (w_complete || w_to_fire) r_to_cnt <= '0;
      else                         r_to_cnt <= r_to_cnt + TO_W'(1);

      // A dead scan overrides whatever the compare stage decided.
      if (w_to_fire) begin
        r_locked <= 1'b0;
        r_match  <= '0;
      end
    end
  end

  assign number       = r_number;
  assign number_valid = r_number_valid;
  assign locked       = r_locked;
  assign frame_err    = r_frame_err;
  assign dp_mask      = r_dp_mask;

endmodule

// File: tb/tb_seg_display_decoder.sv
module tb_seg_display_decoder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  seg;
  logic [3:0]  digit;
  logic [13:0] number;
  logic        number_valid;
  logic        locked;
  logic        frame_err;
  logic [3:0]  dp_mask;

  seg_display_decoder #(
    .SETTLE      (4),
    .MATCH_FRAMES(2),
    .TIMEOUT     (1000),
    .NUM_W       (14)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .seg         (seg),
    .digit       (digit),
    .number      (number),
    .number_valid(number_valid),
    .locked      (locked),
    .frame_err   (frame_err),
    .dp_mask     (dp_mask)
  );

  always #5 CLK = ~CLK;

  int n_checks  = 0;
  int n_errors  = 0;
  int pulse_cnt = 0;
  int ferr_cnt  = 0;

  always @(negedge CLK) begin
    if (number_valid) pulse_cnt++;
    if (frame_err)    ferr_cnt++;
  end

  // Frame patterns packed {thousands, hundreds, tens, ones}, active-low.
  localparam logic [31:0] F4085 = 32'h99C0_8092;
  localparam logic [31:0] F0007 = 32'hFFFF_7FF8;  // tens blank with dp lit
  localparam logic [31:0] FBAD  = 32'hFFD5_7FF8;  // hundreds undecodable

  typedef struct {
    string       name;
    logic [31:0] segs;
    int          frames;
    int          exp_num;
    int          exp_pulses;
    int          exp_errs;
    int          exp_locked;
    int          exp_dp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_slot(input int slot, input logic [7:0] s, input int n);
    digit = ~(4'b0001 << slot);
    seg   = s;
    tick(n);
    digit = 4'hF;
    seg   = 8'hFF;
    tick(8);
  endtask

  task automatic scan_frame(input logic [31:0] segs);
    for (int i = 0; i < 4; i++) drive_slot(i, segs[i*8 +: 8], 64);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " number"},       int'(number),       0);
    check({tag, " number_valid"}, int'(number_valid), 0);
    check({tag, " locked"},       int'(locked),       0);
    check({tag, " frame_err"},    int'(frame_err),    0);
    check({tag, " dp_mask"},      int'(dp_mask),      0);
  endtask

  initial begin
    int p0;
    int e0;

    vecs[0] = '{"4085 x2 publish",   F4085, 2, 4085, 1, 0, 1, 0};
    vecs[1] = '{"4085 x3 no repeat", F4085, 3, 4085, 0, 0, 1, 0};
    vecs[2] = '{"0007 first frame",  F0007, 1, 4085, 0, 0, 0, 0};
    vecs[3] = '{"0007 second frame", F0007, 1, 7,    1, 0, 1, 2};
    vecs[4] = '{"bad digit frame",   FBAD,  1, 7,    0, 1, 0, 2};
    vecs[5] = '{"0007 relock",       F0007, 2, 7,    1, 0, 1, 2};

    RESET = 1'b1;
    seg   = 8'hFF;
    digit = 4'hF;
    tick(3);
    RESET = 1'b0;
    @(negedge CLK);
    check_zero_outputs("reset");
    $display("reset: number=%0d locked=%0d dp_mask=%b", number, locked, dp_mask);
    tick(1);

    for (int v = 0; v < 6; v++) begin
      p0 = pulse_cnt;
      e0 = ferr_cnt;
      for (int f = 0; f < vecs[v].frames; f++) scan_frame(vecs[v].segs);
      @(negedge CLK);
      check({vecs[v].name, " number"},  int'(number),  vecs[v].exp_num);
      check({vecs[v].name, " pulses"},  pulse_cnt - p0, vecs[v].exp_pulses);
      check({vecs[v].name, " errs"},    ferr_cnt - e0,  vecs[v].exp_errs);
      check({vecs[v].name, " locked"},  int'(locked),  vecs[v].exp_locked);
      check({vecs[v].name, " dp_mask"}, int'(dp_mask), vecs[v].exp_dp);
      $display("vec %0d %s: number=%0d pulses=%0d errs=%0d locked=%0d dp_mask=%b",
               v, vecs[v].name, number, pulse_cnt - p0, ferr_cnt - e0, locked, dp_mask);
      tick(1);
    end

    // Short strobe and multi-low anode inserted after the real hundreds slot;
    // either one being captured would change the frame value.
    p0 = pulse_cnt;
    e0 = ferr_cnt;
    drive_slot(0, 8'hF8, 64);
    drive_slot(1, 8'h7F, 64);
    drive_slot(2, 8'hFF, 64);
    drive_slot(2, 8'h80, 3);
    digit = 4'b1100;
    seg   = 8'h80;
    tick(64);
    digit = 4'hF;
    seg   = 8'hFF;
    tick(8);
    drive_slot(3, 8'hFF, 64);
    @(negedge CLK);
    check("glitch number", int'(number), 7);
    check("glitch locked", int'(locked), 1);
    check("glitch pulses", pulse_cnt - p0, 0);
    check("glitch errs",   ferr_cnt - e0, 0);
    $display("glitch frame: number=%0d locked=%0d pulses=%0d", number, locked, pulse_cnt - p0);
    tick(1);

    // Dead scan for TIMEOUT cycles, then resume.
    digit = 4'hF;
    seg   = 8'hFF;
    tick(1000);
    @(negedge CLK);
    check("timeout locked", int'(locked), 0);
    check("timeout number", int'(number), 7);
    $display("timeout: number=%0d locked=%0d", number, locked);
    tick(1);
    p0 = pulse_cnt;
    scan_frame(F0007);
    @(negedge CLK);
    check("resume1 locked", int'(locked), 0);
    check("resume1 pulses", pulse_cnt - p0, 0);
    tick(1);
    scan_frame(F0007);
    @(negedge CLK);
    check("resume2 locked", int'(locked), 1);
    check("resume2 pulses", pulse_cnt - p0, 1);
    check("resume2 number", int'(number), 7);
    $display("resume: number=%0d locked=%0d pulses=%0d", number, locked, pulse_cnt - p0);
    tick(1);

    // Reset after two slots of a frame; the partial frame must be discarded.
    drive_slot(0, 8'h92, 64);
    drive_slot(1, 8'h80, 64);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    @(negedge CLK);
    check_zero_outputs("midreset");
    $display("mid-frame reset: number=%0d locked=%0d dp_mask=%b", number, locked, dp_mask);
    tick(1);
    p0 = pulse_cnt;
    drive_slot(2, 8'hC0, 64);
    drive_slot(3, 8'h99, 64);
    scan_frame(F4085);
    @(negedge CLK);
    check("post-reset frame1 pulses", pulse_cnt - p0, 0);
    check("post-reset frame1 locked", int'(locked), 0);
    tick(1);
    scan_frame(F4085);
    @(negedge CLK);
    check("post-reset frame2 pulses", pulse_cnt - p0, 1);
    check("post-reset frame2 number", int'(number), 4085);
    check("post-reset frame2 locked", int'(locked), 1);
    $display("post-reset: number=%0d locked=%0d pulses=%0d", number, locked, pulse_cnt - p0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_display_decoder.md
Name: seg_display_decoder

Overview:
Decodes the multiplexed 7-segment bus (seg/digit) driven by the display controller back into a binary number. It watches the scan, captures each digit's segment pattern once it has settled, and assembles a full 4-digit frame. It publishes the value once it has been confirmed over consecutive identical frames. Used as an on-chip readback/self-check of the display path and as the bench's display monitor.

Parameters:
SETTLE, 16, cycles a digit strobe must be stable before its segments are captured (min 2)
MATCH_FRAMES, 2, consecutive identical error-free frames required to publish a value (min 1)
TIMEOUT, 500000, CLK cycles without a completed frame before lock is dropped
NUM_W, 14, width of number output (holds 0..9999)

Ports:
CLK  input  1  system clock; the only clock
RESET  input  1  synchronous, active-high reset
seg  input  8  observed segments, active-low; [6:0]=g,f,e,d,c,b,a; [7]=dp
digit  input  4  observed anodes, active-low one-hot; [0]=ones … [3]=thousands
number  output  NUM_W  last published value
number_valid  output  1  one-cycle pulse when number is (re)published
locked  output  1  high while the published value is confirmed and scan is alive
frame_err  output  1  one-cycle pulse when a completed frame contains an undecodable digit
dp_mask  output  4  decimal-point state per digit from the last published frame (1 = lit)

Behaviour:
- Reset (synchronous, RESET=1 at CLK edge): number=0, number_valid=0, locked=0, frame_err=0, dp_mask=0. Also clears the seen mask, error flag, match counter, settle counter and timeout counter. Reset mid-frame discards all partial state.
- Inputs are registered once (seg_q, digit_q); all logic uses the registered copies.
- digit_q is valid only when exactly one bit is 0. 4'b1111 (blank) and multi-low patterns are invalid: the settle counter clears and nothing is captured.
- Settle counter: increments while digit_q is valid and equal to the previous cycle's value; clears on any change.
- Capture: when the counter reaches SETTLE-1, the selected digit slot is captured once per strobe. A capture flag blocks re-capture until digit_q changes.
- On capture, the slot's seen bit is set and its dp is stored. Decode is exact-match, active-low, gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank (1111111) decodes as 0. Any other pattern stores 0 and sets the frame error flag.
- Re-capturing an already-seen slot before frame completion overwrites that slot. An error flag already set stays set.
- Frame complete when seen==4'b1111 (state CAPTURE -> CONVERT). Next cycle, value = d3*1000 + d2*100 + d1*10 + d0, computed at NUM_W bits, then state COMPARE. seen and the error flag clear in the same cycle the frame completes, so capture of the next frame can proceed concurrently.
- COMPARE, error frame: frame_err pulses, match counter=0, locked=0, number and dp_mask hold.
- COMPARE, good frame equal to the previous good frame (value and dp): match counter increments, saturating at MATCH_FRAMES. Otherwise match counter=1 and the frame becomes the new reference.
- Publish: when the match counter transitions to MATCH_FRAMES, number and dp_mask load, number_valid pulses for 1 cycle, and locked=1. Further identical frames do not pulse. A differing good frame drops locked to 0 until it reaches MATCH_FRAMES.
- The first good frame after reset or after an error counts as match 1. With MATCH_FRAMES=1, every good frame that differs from the reference publishes.
- Timeout counter clears on each frame completion. On reaching TIMEOUT: locked=0, match counter=0, seen cleared, counter clears. number holds.
- Latency: number_valid asserts 2 cycles after the CLK edge at which the last slot of the confirming frame is captured.

Test Plan:
- SETTLE=4, MATCH_FRAMES=2: scan 4085, each digit held 64 cycles with 8 blank cycles between. Required: after the 2nd complete frame, number=4085, one number_valid pulse, locked=1, dp_mask=0. Frames 3–5 produce no further pulses.
- Switch scan to blank,blank,blank,7 with dp lit on digit 1. Required: locked drops at the first new frame. After 2 frames, number=7, dp_mask=4'b0010, one pulse.
- Drive seg=8'b11010101 on digit 2 for one frame. Required: frame_err pulse, locked=0, number stays 7. Two more good frames of 0007 republish 7 with a pulse.
- Drive a digit strobe for 3 cycles (< SETTLE) with pattern "8" inside a 0007 scan, plus a multi-low digit=4'b1100. Required: neither is captured and the value is unchanged.
- TIMEOUT=1000: hold digit=4'b1111 for 1000 cycles after lock. Required: locked=0 and number holds. Resumed 0007 scan relocks after 2 frames with a pulse.
- Assert RESET for 1 cycle mid-frame. Required: all outputs 0 next cycle. Partial frame discarded; publish occurs only after 2 fresh full frames.
